// File: rtl/izh_fixed_pkg.sv
// Shared Q9.7 fixed-point constants and the step-sequencer state encoding
// used across the Izhikevich neuron datapath.
package izh_fixed_pkg;

   localparam int Q_W    = 16;
   localparam int Q_FRAC = 7;

   localparam logic [Q_W-1:0] Q_THRESH_30 = 16'h0F00;
   localparam logic [Q_W-1:0] Q_C_DEFAULT = 16'hDF80;  // -65.0
   localparam logic [Q_W-1:0] Q_D_DEFAULT = 16'h0400;  //   8.0

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ISSUE  = 3'd1,
      S_WAIT   = 3'd2,
      S_FINISH = 3'd3,
      S_ERROR  = 3'd4,
      S_DRAIN  = 3'd5
   } seq_state_t;

   function automatic logic [Q_W-1:0] q_add(input logic [Q_W-1:0] a,
                                            input logic [Q_W-1:0] b);
      return a + b;
   endfunction

endpackage

// File: rtl/izh_step_sequencer.sv
// Drives the RK4 Izhikevich solver one step at a time, applies the
// after-spike reset and emits one registered sample per completed step.
module izh_step_sequencer
   import izh_fixed_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int STEP_W         = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   input  logic              abort,
   input  logic [STEP_W-1:0] num_steps,
   input  logic [Q_W-1:0]    v_init,
   input  logic [Q_W-1:0]    u_init,
   input  logic [Q_W-1:0]    c_param,
   input  logic [Q_W-1:0]    d_param,
   input  logic [Q_W-1:0]    I_const,
   output logic              solver_start,
   output logic [Q_W-1:0]    solver_v_in,
   output logic [Q_W-1:0]    solver_u_in,
   output logic [Q_W-1:0]    solver_I_in,
   input  logic [Q_W-1:0]    solver_v_out,
   input  logic [Q_W-1:0]    solver_u_out,
   input  logic              solver_spike,
   input  logic              solver_done,
   output logic              sample_valid,
   output logic [Q_W-1:0]    sample_v,
   output logic [Q_W-1:0]    sample_u,
   output logic              sample_spike,
   output logic [STEP_W-1:0] step_count,
   output logic [STEP_W-1:0] spike_count,
   output logic              busy,
   output logic              finished,
   output logic              error
);

   localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   seq_state_t        state_q, state_d;
   logic [STEP_W-1:0] num_steps_q, num_steps_d;
   logic [Q_W-1:0]    cparam_q, cparam_d;
   logic [Q_W-1:0]    dparam_q, dparam_d;
   logic [Q_W-1:0]    icur_q, icur_d;
   logic [Q_W-1:0]    v_q, v_d;
   logic [Q_W-1:0]    u_q, u_d;
   logic [WD_W-1:0]   wd_q, wd_d;
   logic              sample_valid_q, sample_valid_d;
   logic [Q_W-1:0]    sample_v_q, sample_v_d;
   logic [Q_W-1:0]    sample_u_q, sample_u_d;
   logic              sample_spike_q, sample_spike_d;
   logic [STEP_W-1:0] step_count_q, step_count_d;
   logic [STEP_W-1:0] spike_count_q, spike_count_d;
   logic              busy_q, busy_d;
   logic              finished_q, finished_d;
   logic              error_q, error_d;

   logic              spike_evt;
   logic [STEP_W-1:0] step_next;

   // The solver's threshold compare is unsigned; negative potentials are not spikes.
   assign spike_evt = solver_spike && !solver_v_out[Q_W-1];
   assign step_next = step_count_q + STEP_W'(1);

   always_comb begin
      state_d        = state_q;
      num_steps_d    = num_steps_q;
      cparam_d       = cparam_q;
      dparam_d       = dparam_q;
      icur_d         = icur_q;
      v_d            = v_q;
      u_d            = u_q;
      wd_d           = wd_q;
      sample_valid_d = 1'b0;
      sample_v_d     = sample_v_q;
      sample_u_d     = sample_u_q;
      sample_spike_d = sample_spike_q;
      step_count_d   = step_count_q;
      spike_count_d  = spike_count_q;
      error_d        = error_q;
      finished_d     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (run) begin
               num_steps_d   = num_steps;
               cparam_d      = c_param;
               dparam_d      = d_param;
               icur_d        = I_const;
               v_d           = v_init;
               u_d           = u_init;
               step_count_d  = '0;
               spike_count_d = '0;
               error_d       = 1'b0;
               state_d       = (num_steps == '0) ? S_FINISH : S_ISSUE;
            end
         end
         S_ISSUE: begin
            wd_d    = '0;
            state_d = abort ? S_IDLE : S_WAIT;
         end
         S_WAIT: begin
            wd_d = wd_q + WD_W'(1);
            if (abort) begin
               // A done in the abort cycle is already consumed, so no drain is needed.
               state_d = solver_done ? S_IDLE : S_DRAIN;
            end else if (solver_done) begin
               if (spike_evt) begin
                  v_d = cparam_q;
                  u_d = q_add(solver_u_out, dparam_q);
                  if (spike_count_q != '1) begin
                     spike_count_d = spike_count_q + STEP_W'(1);
                  end
               end else begin
                  v_d = solver_v_out;
                  u_d = solver_u_out;
               end
               sample_valid_d = 1'b1;
               sample_v_d     = v_d;
               sample_u_d     = u_d;
               sample_spike_d = spike_evt;
               step_count_d   = step_next;
               state_d        = (step_next == num_steps_q) ? S_FINISH : S_ISSUE;
            end else if (wd_q == WD_LAST) begin
               error_d = 1'b1;
               state_d = S_ERROR;
            end
         end
         S_FINISH: begin
            finished_d = !abort;
            state_d    = S_IDLE;
         end
         S_ERROR: begin
            if (abort) begin
               state_d = S_IDLE;
            end
         end
         S_DRAIN: begin
            wd_d = wd_q + WD_W'(1);
            if (solver_done || (wd_q >= WD_LAST)) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Busy spans the trailing finished pulse, which lands after FINISH is left.
      busy_d = (state_d != S_IDLE) || finished_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= S_IDLE;
         num_steps_q    <= '0;
         cparam_q       <= '0;
         dparam_q       <= '0;
         icur_q         <= '0;
         v_q            <= '0;
         u_q            <= '0;
         wd_q           <= '0;
         sample_valid_q <= 1'b0;
         sample_v_q     <= '0;
         sample_u_q     <= '0;
         sample_spike_q <= 1'b0;
         step_count_q   <= '0;
         spike_count_q  <= '0;
         busy_q         <= 1'b0;
         finished_q     <= 1'b0;
         error_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         num_steps_q    <= num_steps_d;
         cparam_q       <= cparam_d;
         dparam_q       <= dparam_d;
         icur_q         <= icur_d;
         v_q            <= v_d;
         u_q            <= u_d;
         wd_q           <= wd_d;
         sample_valid_q <= sample_valid_d;
         sample_v_q     <= sample_v_d;
         sample_u_q     <= sample_u_d;
         sample_spike_q <= sample_spike_d;
         step_count_q   <= step_count_d;
         spike_count_q  <= spike_count_d;
         busy_q         <= busy_d;
         finished_q     <= finished_d;
         error_q        <= error_d;
      end
   end

   // An abort in ISSUE suppresses the request so the solver is never left mid-step.
   assign solver_start = (state_q == S_ISSUE) && !abort;
   assign solver_v_in  = v_q;
   assign solver_u_in  = u_q;
   assign solver_I_in  = icur_q;
   assign sample_valid = sample_valid_q;
   assign sample_v     = sample_v_q;
   assign sample_u     = sample_u_q;
   assign sample_spike = sample_spike_q;
   assign step_count   = step_count_q;
   assign spike_count  = spike_count_q;
   assign busy         = busy_q;
   assign finished     = finished_q;
   assign error        = error_q;

endmodule

// File: tb/tb_izh_step_sequencer.sv
// Directed bench for izh_step_sequencer with a fixed-latency solver model;
// expected values are hand-computed Q9.7 constants.
module tb_izh_step_sequencer;
   import izh_fixed_pkg::*;

   localparam int TIMEOUT = 64;

   logic        clk = 1'b0;
   logic        reset;
   logic        run;
   logic        abort;
   logic [15:0] num_steps;
   logic [15:0] v_init, u_init, c_param, d_param, I_const;
   logic        solver_start;
   logic [15:0] solver_v_in, solver_u_in, solver_I_in;
   logic [15:0] solver_v_out, solver_u_out;
   logic        solver_spike, solver_done;
   logic        sample_valid;
   logic [15:0] sample_v, sample_u;
   logic        sample_spike;
   logic [15:0] step_count, spike_count;
   logic        busy, finished, error;

   always #5 clk = ~clk;

   izh_step_sequencer #(
      .TIMEOUT_CYCLES(TIMEOUT),
      .STEP_W        (16)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .run         (run),
      .abort       (abort),
      .num_steps   (num_steps),
      .v_init      (v_init),
      .u_init      (u_init),
      .c_param     (c_param),
      .d_param     (d_param),
      .I_const     (I_const),
      .solver_start(solver_start),
      .solver_v_in (solver_v_in),
      .solver_u_in (solver_u_in),
      .solver_I_in (solver_I_in),
      .solver_v_out(solver_v_out),
      .solver_u_out(solver_u_out),
      .solver_spike(solver_spike),
      .solver_done (solver_done),
      .sample_valid(sample_valid),
      .sample_v    (sample_v),
      .sample_u    (sample_u),
      .sample_spike(sample_spike),
      .step_count  (step_count),
      .spike_count (spike_count),
      .busy        (busy),
      .finished    (finished),
      .error       (error)
   );

   // Solver model: done pulses 13 cycles after the start cycle (step period 14).
   int sol_lat  = 12;
   bit sol_hang = 1'b0;
   int sol_cnt  = 0;

   initial begin
      solver_done = 1'b0;
      forever begin
         @(negedge clk);
         solver_done = 1'b0;
         if (solver_start) begin
            sol_cnt = sol_lat + 1;
         end else if (sol_cnt > 0) begin
            sol_cnt = sol_cnt - 1;
            if (sol_cnt == 0 && !sol_hang) solver_done = 1'b1;
         end
      end
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_run(input logic [15:0] ns, input logic [15:0] v0, input logic [15:0] u0,
                            input logic [15:0] c, input logic [15:0] d, input logic [15:0] i);
      num_steps = ns;
      v_init    = v0;
      u_init    = u0;
      c_param   = c;
      d_param   = d;
      I_const   = i;
      run       = 1'b1;
      tick();
      run       = 1'b0;
   endtask

   task automatic wait_sample(input string tag, input int exp_gap);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (!sample_valid && n < 100);
      $display("sample %s: gap=%0d v=%h u=%h spike=%b step=%0d spikes=%0d",
               tag, n, sample_v, sample_u, sample_spike, step_count, spike_count);
      check_eq(tag, n, exp_gap);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no end of run expected end of run");
      $fatal(1, "bench timeout");
   end

   initial begin
      int n;
      bit seen;

      reset        = 1'b1;
      run          = 1'b0;
      abort        = 1'b0;
      num_steps    = '0;
      v_init       = '0;
      u_init       = '0;
      c_param      = '0;
      d_param      = '0;
      I_const      = '0;
      solver_v_out = '0;
      solver_u_out = '0;
      solver_spike = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_busy", busy, 0);
      check_eq("rst_start", solver_start, 0);
      check_eq("rst_vin", solver_v_in, 0);
      check_eq("rst_step", step_count, 0);
      check_eq("rst_err", error, 0);
      reset = 1'b0;
      tick();

      // Three steps, no spikes, 14-cycle period
      solver_v_out = 16'h0500;
      solver_u_out = 16'hFF00;
      solver_spike = 1'b0;
      start_run(16'd3, 16'hF800, 16'hFE00, Q_C_DEFAULT, Q_D_DEFAULT, 16'h0A00);
      check_eq("t1_start", solver_start, 1);
      check_eq("t1_busy", busy, 1);
      check_eq("t1_vin", solver_v_in, 16'hF800);
      check_eq("t1_uin", solver_u_in, 16'hFE00);
      check_eq("t1_iin", solver_I_in, 16'h0A00);
      wait_sample("t1_gap1", 14);
      check_eq("t1_sv", sample_v, 16'h0500);
      check_eq("t1_su", sample_u, 16'hFF00);
      check_eq("t1_sspk", sample_spike, 0);
      check_eq("t1_step1", step_count, 1);
      check_eq("t1_restart", solver_start, 1);
      check_eq("t1_vin2", solver_v_in, 16'h0500);
      wait_sample("t1_gap2", 14);
      wait_sample("t1_gap3", 14);
      check_eq("t1_step3", step_count, 3);
      check_eq("t1_nostart", solver_start, 0);
      check_eq("t1_fin_early", finished, 0);
      tick();
      check_eq("t1_fin", finished, 1);
      check_eq("t1_fin_busy", busy, 1);
      tick();
      check_eq("t1_fin_end", finished, 0);
      check_eq("t1_idle_busy", busy, 0);

      // Positive spike: v <- c, u <- u + d
      solver_v_out = 16'h1000;
      solver_u_out = 16'hF980;
      solver_spike = 1'b1;
      start_run(16'd2, 16'h0000, 16'h0000, 16'hDF80, 16'h0400, 16'h0000);
      wait_sample("t2_gap1", 14);
      check_eq("t2_sv", sample_v, 16'hDF80);
      check_eq("t2_su", sample_u, 16'hFD80);
      check_eq("t2_sspk", sample_spike, 1);
      check_eq("t2_spk1", spike_count, 1);
      check_eq("t2_vin", solver_v_in, 16'hDF80);
      check_eq("t2_uin", solver_u_in, 16'hFD80);
      wait_sample("t2_gap2", 14);
      check_eq("t2_spk2", spike_count, 2);
      tick();
      check_eq("t2_fin", finished, 1);
      tick();

      // Negative potential flagged as spike is masked
      solver_v_out = 16'hDF80;
      solver_u_out = 16'h0123;
      solver_spike = 1'b1;
      start_run(16'd1, 16'h0100, 16'h0200, 16'hDF80, 16'h0400, 16'h0000);
      wait_sample("t3_gap", 14);
      check_eq("t3_sspk", sample_spike, 0);
      check_eq("t3_sv", sample_v, 16'hDF80);
      check_eq("t3_su", sample_u, 16'h0123);
      check_eq("t3_spk", spike_count, 0);
      check_eq("t3_vin", solver_v_in, 16'hDF80);
      tick();
      tick();

      // Watchdog timeout, abort out of ERROR, next run clears error
      solver_spike = 1'b0;
      sol_hang     = 1'b1;
      start_run(16'd1, 16'h0000, 16'h0000, Q_C_DEFAULT, Q_D_DEFAULT, 16'h0000);
      repeat (TIMEOUT) tick();
      check_eq("t4_err_early", error, 0);
      tick();
      check_eq("t4_err", error, 1);
      check_eq("t4_err_busy", busy, 1);
      tick();
      check_eq("t4_err_stay", error, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_eq("t4_abort_idle", busy, 0);
      check_eq("t4_err_sticky", error, 1);
      sol_hang = 1'b0;

      // num_steps == 0: finished pulse, no solver request
      start_run(16'd0, 16'h0000, 16'h0000, Q_C_DEFAULT, Q_D_DEFAULT, 16'h0000);
      check_eq("t4_err_clr", error, 0);
      check_eq("t6_zero_nostart", solver_start, 0);
      check_eq("t6_zero_busy", busy, 1);
      check_eq("t6_zero_fin_early", finished, 0);
      tick();
      check_eq("t6_zero_fin", finished, 1);
      check_eq("t6_zero_nostart2", solver_start, 0);
      tick();
      check_eq("t6_zero_idle", busy, 0);
      tick();

      // Abort in WAIT: drain the outstanding done, then a clean run
      solver_v_out = 16'h0300;
      solver_u_out = 16'h0040;
      start_run(16'd2, 16'h0000, 16'h0000, Q_C_DEFAULT, Q_D_DEFAULT, 16'h0000);
      repeat (5) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_eq("t5_drain_busy", busy, 1);
      n    = 0;
      seen = 1'b0;
      do begin
         tick();
         n++;
         if (sample_valid) seen = 1'b1;
      end while (busy && n < 40);
      $display("abort drain: idle after %0d cycles, sample_seen=%b", n, seen);
      check_eq("t5_drain_len", n, 8);
      check_eq("t5_no_sample", seen, 0);
      check_eq("t5_step_kept", step_count, 0);
      solver_v_out = 16'h0777;
      solver_u_out = 16'h0011;
      start_run(16'd1, 16'h0100, 16'h0000, Q_C_DEFAULT, Q_D_DEFAULT, 16'h0000);
      wait_sample("t5_clean_gap", 14);
      check_eq("t5_clean_sv", sample_v, 16'h0777);
      check_eq("t5_clean_su", sample_u, 16'h0011);
      check_eq("t5_clean_step", step_count, 1);
      tick();
      tick();

      // Asynchronous reset in the middle of WAIT
      solver_v_out = 16'h0222;
      solver_u_out = 16'h0033;
      start_run(16'd3, 16'h0AAA, 16'h0BBB, Q_C_DEFAULT, Q_D_DEFAULT, 16'h0055);
      wait_sample("t6_pre_gap", 14);
      check_eq("t6_pre_step", step_count, 1);
      repeat (4) tick();
      reset = 1'b1;
      #1;
      check_eq("t6_rst_busy", busy, 0);
      check_eq("t6_rst_step", step_count, 0);
      check_eq("t6_rst_sv", sample_v, 0);
      check_eq("t6_rst_vin", solver_v_in, 0);
      check_eq("t6_rst_iin", solver_I_in, 0);
      check_eq("t6_rst_start", solver_start, 0);
      #1;
      reset = 1'b0;
      repeat (20) tick();
      check_eq("t6_post_busy", busy, 0);
      check_eq("t6_post_step", step_count, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/izh_step_sequencer.md
# izh_step_sequencer

Host-side initiator for the RK4 Izhikevich step solver. Seeds the solver with an initial (v, u), issues one solver step per iteration over a start/done handshake, and applies the Izhikevich after-spike reset (v ← c, u ← u + d). It iterates a programmed number of steps and emits one registered sample per step. It sits between the host/testbench register interface and the solver; both are instantiated side by side in the neuron top level.

## Interface
- `TIMEOUT_CYCLES`, 64 — maximum cycles from `solver_start` to `solver_done` before the run is declared failed.
- `STEP_W`, 16 — width of step and spike counters.
- `clk` in 1 — single clock, rising edge.
- `reset` in 1 — asynchronous, active-high.
- `run` in 1 — start request, sampled in IDLE only.
- `abort` in 1 — synchronous cancel, honoured in any non-IDLE state.
- `num_steps` in STEP_W — steps per run, latched on run.
- `v_init`, `u_init` in 16 — Q9.7 initial state, latched on run.
- `c_param`, `d_param` in 16 — Q9.7 reset values, latched on run.
- `I_const` in 16 — Q9.7 input current, latched on run.
- `solver_start` out 1 — one-cycle step request to the solver.
- `solver_v_in`, `solver_u_in`, `solver_I_in` out 16 — operands to the solver, registered.
- `solver_v_out`, `solver_u_out` in 16 — solver results, valid when `solver_done`=1.
- `solver_spike`, `solver_done` in 1 — solver flags; `solver_done` is a one-cycle pulse.
- `sample_valid` out 1 — one-cycle pulse per completed step.
- `sample_v`, `sample_u` out 16 — post-reset state for that step.
- `sample_spike` out 1 — spike occurred on that step.
- `step_count`, `spike_count` out STEP_W — progress counters.
- `busy`, `finished`, `error` out 1 — status; `finished` is a one-cycle pulse; `error` is sticky.

## Operation
- All values are Q9.7 two's complement, 16 bit, with 7 fractional bits. Addition wraps mod 2^16; there is no saturation.
- Spike qualification: `spike_evt = solver_spike && !solver_v_out[15]`. The solver's threshold compare is unsigned, so negative potentials are masked here.
- States:
  - **IDLE**
    - `busy`=0.
    - On `run`: latch all inputs, load the state registers with `v_init`/`u_init`, clear both counters and `error`.
    - Go to FINISH if `num_steps`==0, else to ISSUE.
  - **ISSUE**
    - `solver_start`=1 for exactly this cycle; clear the watchdog.
    - Go to WAIT.
  - **WAIT**
    - Watchdog increments each cycle.
    - On `solver_done`:
      - If `spike_evt`: v ← c, u ← `solver_u_out` + d.
      - Else: v ← `solver_v_out`, u ← `solver_u_out`.
      - Load the sample registers; `step_count`+1; `spike_count`+1 on spike, saturating at all-ones.
      - Go to FINISH if the new `step_count` == `num_steps`, else to ISSUE.
    - If the watchdog reaches `TIMEOUT_CYCLES` without `solver_done`: go to ERROR.
  - **FINISH**
    - `finished`=1 for one cycle.
    - Go to IDLE.
  - **ERROR**
    - `error`=1; stays here until `abort`, then goes to IDLE.
  - **DRAIN**
    - Entered on `abort` from WAIT.
    - Waits for `solver_done` (result discarded) or watchdog expiry, then goes to IDLE.
    - Purpose: a stale `solver_done` must never be attributed to a new run.
- `abort` in ISSUE, FINISH or ERROR goes to IDLE directly. `abort` and `solver_done` in the same WAIT cycle: abort wins, no sample, go to IDLE.
- `solver_v_in`/`solver_u_in`/`solver_I_in` stay constant from ISSUE until `solver_done` is consumed. The solver reads its inputs across all internal phases, so this is required.
- `run` while busy is ignored.

## Timing
- Reset values: every output is 0, the state machine is in IDLE, and all internal registers are 0.
- `run` sampled at edge N → `solver_start` high in cycle N+1.
- `solver_done` sampled at edge M → `sample_valid`/`sample_*`/counters update in cycle M+1. `solver_start` for the next step is also high in cycle M+1.
- Step period = solver latency + 2 cycles.
- `finished` is high the cycle after the last sample.
- `busy` is high from cycle N+1 through the cycle in which `finished` is high.
- Timeout: `error` is high TIMEOUT_CYCLES+1 cycles after `solver_start`.

## Structure
- Shared package `izh_fixed_pkg`:
  - Q9.7 width and fractional-bit constants.
  - `Q_THRESH_30` = 0x0F00.
  - Sequencer state enum.
  - Default constants c = −65.0 (0xDF80) and d = 8.0 (0x0400).
- No sub-module: the watchdog and counters are inline. The solver is instantiated by the parent, not inside this block.

## Test plan
- Solver model with fixed 12-cycle latency; `num_steps`=3, no spikes → three `sample_valid` pulses 14 cycles apart; `step_count`=3; `finished` one cycle after the third sample.
- Solver returns v=0x1000, u=0xF980, spike=1; c=0xDF80, d=0x0400 → `sample_v`=0xDF80, `sample_u`=0xFD80, `sample_spike`=1, `spike_count`=1; next `solver_v_in`=0xDF80.
- Solver returns v=0xDF80 with spike=1 (negative, unsigned-compare artefact) → `sample_spike`=0, state v=0xDF80, u unchanged by d.
- Solver never asserts done, TIMEOUT_CYCLES=64 → `error`=1 at cycle 65 after start; `abort` returns to IDLE; the next `run` clears `error`.
- `abort` at cycle 5 of WAIT; solver done arrives at cycle 12 → no `sample_valid`; IDLE reached the cycle after done; an immediate new `run` gets a clean first sample.
- `num_steps`=0 → `finished` pulse, no `solver_start`. Asynchronous `reset` mid-WAIT → all outputs 0 immediately.
